// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Takes bitstream words over a valid/ready interface and shifts them, LSB
// first, into the head of a tile-column configuration chain. All of this
// happens in the prog_clk domain. Chain shifting is gated by ccff_shift_en.
// The bits leaving ccff_tail on the same edges can be captured and returned
// as readback words.
//
// Parameters
//   WORD_W     width of bitstream / readback words (2..32)
//   CHAIN_LEN  number of configuration bits in the attached chain (>=1)
//
// Ports
//   prog_clk       block and chain clock
//   prog_reset     asynchronous reset, active low
//   start          one-cycle request for a full-chain load (ignored when busy)
//   wr_data        bitstream word, bit 0 shifted first
//   wr_valid       wr_data valid
//   wr_ready       word accepted when wr_valid && wr_ready
//   ccff_head      registered serial data into the chain head
//   ccff_shift_en  registered chain clock-enable
//   ccff_tail      serial data out of the chain tail
//   rd_data        readback word, bit i = tail value in shift cycle i
//   rd_valid       readback word available
//   rd_ready       readback consumed when rd_valid && rd_ready
//   busy           high from start acceptance until done
//   done           one-cycle pulse after the last chain bit
//
// Build option
//   CCFF_READBACK_EN  When defined, the tail capture and the readback word
//                     slot are built. When it is not defined, rd_data and
//                     rd_valid stay 0, rd_ready is ignored, and wr_ready in
//                     LOAD is always 1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start, counters cleared on start
// LOAD   | waiting for the next bitstream word (and a free readback slot)
// SHIFT  | one chain bit per cycle until the current word is exhausted
// FINISH | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = $clog2(WORD_W);
   localparam int LEN_W = $clog2(WORD_W + 1);
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_SHIFT  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [LEN_W-1:0]  r_word_len;
   logic [LEN_W-1:0]  w_word_len;
   logic [WORD_W-1:0] r_shreg;
   logic              r_head;
   logic              r_shift_en;
   logic [31:0]       w_remain;
   logic              w_accept;
   logic              w_shifting;
   logic              w_word_last;
   logic              w_chain_last;
   logic              w_slot_free;

   // Bits still owed to the chain; a short final word only covers the rest.
   assign w_remain     = 32'(CHAIN_LEN) - 32'(r_bit_cnt);
   assign w_word_len   = (w_remain < 32'(WORD_W)) ? LEN_W'(w_remain) : LEN_W'(WORD_W);
   assign w_shifting   = (r_state == S_SHIFT);
   assign w_word_last  = (32'(r_idx) + 32'd1) == 32'(r_word_len);
   assign w_chain_last = (32'(r_bit_cnt) + 32'd1) == 32'(CHAIN_LEN);

   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wr_ready    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            wr_ready = w_slot_free;
            if (wr_valid && w_slot_free) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_word_last) begin
               w_state_nxt = w_chain_last ? S_FINISH : S_LOAD;
            end
         end
         S_FINISH: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ccff_head/ccff_shift_en are registered. The first head bit is set up on
   // the accept edge, so the chain sees it during the first shift cycle.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         r_bit_cnt  <= '0;
         r_idx      <= '0;
         r_word_len <= '0;
         r_shreg    <= '0;
         r_head     <= 1'b0;
         r_shift_en <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
         end
         if (w_accept) begin
            r_shreg    <= wr_data;
            r_word_len <= w_word_len;
            r_idx      <= '0;
            r_head     <= wr_data[0];
            r_shift_en <= 1'b1;
         end
         if (w_shifting) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_word_last) begin
               r_idx      <= '0;
               r_head     <= 1'b0;
               r_shift_en <= 1'b0;
            end else begin
               r_idx  <= r_idx + IDX_W'(1);
               r_head <= r_shreg[1];
            end
         end
      end
   end

   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;

`ifdef CCFF_READBACK_EN
   logic [WORD_W-1:0] r_rd_shreg;
   logic [WORD_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic [WORD_W-1:0] w_rd_cap;
   logic [WORD_W-1:0] w_len_mask;

   // Capture vector including the tail bit sampled on this edge, so the
   // final bit of a word lands in rd_data on the same edge.
   always_comb begin
      w_rd_cap        = r_rd_shreg;
      w_rd_cap[r_idx] = ccff_tail;
   end

   assign w_len_mask = ~({WORD_W{1'b1}} << r_word_len);

   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         r_rd_shreg <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_shifting) begin
            r_rd_shreg <= w_rd_cap;
         end
         // A completing word wins over a consume in the same cycle.
         if (w_shifting && w_word_last) begin
            r_rd_data  <= w_rd_cap & w_len_mask;
            r_rd_valid <= 1'b1;
         end else if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign w_slot_free = !r_rd_valid || rd_ready;
`else
   logic w_unused_rd;

   assign rd_data     = '0;
   assign rd_valid    = 1'b0;
   assign w_slot_free = 1'b1;
   assign w_unused_rd = rd_ready ^ ccff_tail;
`endif

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Word-to-serial configuration loader that drives the configuration-chain (`ccff_head` → `ccff_tail`) of a tile column from the `prog_clk` domain. It accepts bitstream words over a valid/ready interface and shifts them bit-serially into `ccff_head`. It gates chain shifting through a clock-enable and captures the bits falling out of `ccff_tail` as readback words. It sits between the bitstream source (test controller or configuration memory) and the head of the chain of `logical_tile_*` instances.

## Interface
Parameters:
- `WORD_W`, 8, width of bitstream and readback words (2..32).
- `CHAIN_LEN`, 64, total configuration bits in the attached chain (≥1).

Ports:
- `prog_clk`  in  1  single clock for the block and the chain.
- `prog_reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a full-chain load; ignored while `busy`.
- `wr_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `wr_valid`  in  1  `wr_data` valid.
- `wr_ready`  out  1  word accepted when `wr_valid && wr_ready`.
- `ccff_head`  out  1  serial data into the chain head.
- `ccff_shift_en`  out  1  chain clock-enable; the chain shifts on the `prog_clk` edge ending a cycle where this is 1.
- `ccff_tail`  in  1  serial data out of the chain tail.
- `rd_data`  out  WORD_W  readback word; bit i is the tail value in shift cycle i of that word.
- `rd_valid`  out  1  readback word available.
- `rd_ready`  in  1  readback consumed when `rd_valid && rd_ready`.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the last chain bit is shifted.

## Operation
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE: `start` → LOAD. Clears the total bit counter `bit_cnt` (range 0..CHAIN_LEN) and the word bit index `idx`.
- LOAD: `wr_ready` = `!rd_valid || rd_ready`. On accept, latch the word into the shift register, set `word_len` = min(WORD_W, CHAIN_LEN − bit_cnt), and go to SHIFT.
- SHIFT: each cycle drives `ccff_shift_en`=1 and `ccff_head`=shreg[0]. It samples `ccff_tail` into `rd_shreg[idx]`, then shifts `shreg` right and increments `idx` and `bit_cnt`.
  - When `idx` reaches `word_len`−1: load `rd_data` from `rd_shreg` with bits ≥ `word_len` zeroed, and set `rd_valid`.
  - Then go to FINISH if `bit_cnt`+1 == CHAIN_LEN, else back to LOAD.
- FINISH: pulse `done` and go to IDLE.
- Partial last word: when CHAIN_LEN mod WORD_W = r ≠ 0, the final word shifts only its low r bits. Its upper bits are discarded and never appear on `ccff_head`.
- `rd_valid` clears on `rd_valid && rd_ready`. A word completing readback in the same cycle as the consume sets `rd_valid` and wins.
- Extra `wr_valid` outside LOAD is not accepted. `start` in any state other than IDLE is ignored.
- Reset mid-operation (any state) → IDLE immediately. Chain contents are then undefined and the full load must be repeated.

## Timing
- Reset values: `wr_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0.
- `start` at cycle S → `busy`=1 and `wr_ready` eligible at S+1.
- Word accepted at T → shift cycles T+1..T+L, where L=`word_len`.
- `rd_valid`=1 from T+L+1. Next `wr_ready` at T+L+1, or later if the readback slot is full.
- Sustained throughput: WORD_W bits per WORD_W+1 cycles with `rd_ready` held high.
- `done` is high for exactly cycle F+1, where F is the final shift cycle. `busy` falls at F+2.
- `ccff_head` and `ccff_shift_en` are registered outputs. `ccff_tail` is sampled on the same edge that shifts the chain.

## Configuration
- `CCFF_READBACK_EN` defined: the readback path is present as described.
- Not defined:
  - `rd_shreg`/`rd_data` are not built.
  - `rd_data`=0 and `rd_valid`=0 permanently, and `rd_ready` is ignored.
  - `wr_ready` in LOAD is unconditionally 1.
  - All other timing is unchanged.

## Test plan
- Reset: assert `prog_reset`=0 mid-SHIFT → all outputs return to reset values within the same cycle, and the state is IDLE after release.
- WORD_W=8, CHAIN_LEN=16, words 0xA5 then 0x3C, `rd_ready`=1 → `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with `ccff_shift_en` high for 16 cycles. `done` pulses 1 cycle after the 16th shift.
- Readback: preload the chain model with 0xFFFF, then load 0x00,0x00 → `rd_data` = 0xFF twice. A second load of 0x12,0x34 returns 0x00,0x00.
- Partial word: CHAIN_LEN=20, words 0xFF,0xFF,0xFA → exactly 20 shift cycles; the last word contributes bits 0xA only. Last `rd_data` has bits 7:4 = 0.
- Backpressure: hold `rd_ready`=0 after the first word → `wr_ready` stays 0 and `ccff_shift_en` stays 0. Releasing `rd_ready` gives `wr_ready`=1 in the same cycle.
- `start` pulsed during SHIFT is ignored. With `CCFF_READBACK_EN` undefined, `rd_valid` stays 0 and words are accepted back-to-back every WORD_W+1 cycles.
